// File: rtl/nec_ir_receiver.sv
// NEC infrared remote decoder: turns the demodulated IR pin into a 32-bit frame plus repeat/error pulses.
// Optional build macro IR_ADDR_CHECK_EN also requires the address byte pair to be complementary.
module nec_ir_receiver #(
    parameter int LEAD_LOW_MIN = 400000,
    parameter int LEAD_LOW_MAX = 500000,
    parameter int GAP_DATA_MIN = 175000,
    parameter int GAP_DATA_MAX = 275000,
    parameter int GAP_RPT_MIN  = 87500,
    parameter int GAP_RPT_MAX  = 137500,
    parameter int BURST_MIN    = 15000,
    parameter int BURST_MAX    = 45000,
    parameter int SPACE0_MIN   = 15000,
    parameter int SPACE0_MAX   = 45000,
    parameter int SPACE1_MIN   = 65000,
    parameter int SPACE1_MAX   = 105000,
    parameter int RPT_WINDOW   = 7500000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        IRDA_RXD,
    output logic [31:0] hex_data,
    output logic        data_valid,
    output logic        repeat_valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        RPT_TAIL
    } state_t;

    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;
    localparam logic [19:0] LL_MIN   = 20'(LEAD_LOW_MIN);
    localparam logic [19:0] LL_MAX   = 20'(LEAD_LOW_MAX);
    localparam logic [19:0] GD_MIN   = 20'(GAP_DATA_MIN);
    localparam logic [19:0] GD_MAX   = 20'(GAP_DATA_MAX);
    localparam logic [19:0] GR_MIN   = 20'(GAP_RPT_MIN);
    localparam logic [19:0] GR_MAX   = 20'(GAP_RPT_MAX);
    localparam logic [19:0] BU_MIN   = 20'(BURST_MIN);
    localparam logic [19:0] BU_MAX   = 20'(BURST_MAX);
    localparam logic [19:0] S0_MIN   = 20'(SPACE0_MIN);
    localparam logic [19:0] S0_MAX   = 20'(SPACE0_MAX);
    localparam logic [19:0] S1_MIN   = 20'(SPACE1_MIN);
    localparam logic [19:0] S1_MAX   = 20'(SPACE1_MAX);
    localparam logic [22:0] WIN_LOAD = 23'(RPT_WINDOW);

    state_t      state;
    logic        sync1, sync2, sync3;
    logic        rise, fall;
    logic [19:0] cnt;
    logic [31:0] shreg;
    logic [4:0]  bit_cnt;
    logic [22:0] rpt_win;
    logic        checksum_ok;
    logic        burst_ok, space0_ok, space1_ok;

    // The synchronizer is left unreset so a line already low at reset release is not seen as a fresh edge.
    always_ff @(posedge CLOCK_50) begin
        sync1 <= IRDA_RXD;
        sync2 <= sync1;
        sync3 <= sync2;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
            cnt  <= '0;
        end else begin
            rise <= sync2 & ~sync3;
            fall <= ~sync2 & sync3;
            if (rise | fall)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 20'd1;
        end
    end

    assign burst_ok  = (cnt >= BU_MIN) && (cnt <= BU_MAX);
    assign space0_ok = (cnt >= S0_MIN) && (cnt <= S0_MAX);
    assign space1_ok = (cnt >= S1_MIN) && (cnt <= S1_MAX);

`ifdef IR_ADDR_CHECK_EN
    assign checksum_ok = (shreg[31:24] == ~shreg[23:16]) && (shreg[15:8] == ~shreg[7:0]);
`else
    assign checksum_ok = (shreg[31:24] == ~shreg[23:16]);
`endif

    assign busy = (state != IDLE);

    // Protocol FSM; every pulse output is registered here and cleared by default each cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state        <= IDLE;
            hex_data     <= '0;
            data_valid   <= 1'b0;
            repeat_valid <= 1'b0;
            frame_err    <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            rpt_win      <= '0;
        end else begin
            data_valid   <= 1'b0;
            repeat_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (rpt_win != '0)
                rpt_win <= rpt_win - 23'd1;

            case (state)
                IDLE: begin
                    if (fall)
                        state <= LEAD_LOW;
                end
                LEAD_LOW: begin
                    if (rise) begin
                        if (cnt >= LL_MIN && cnt <= LL_MAX) begin
                            state <= LEAD_HIGH;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                LEAD_HIGH: begin
                    if (fall) begin
                        if (cnt >= GD_MIN && cnt <= GD_MAX) begin
                            bit_cnt <= '0;
                            state   <= BIT_LOW;
                        end else if (cnt >= GR_MIN && cnt <= GR_MAX) begin
                            state <= RPT_TAIL;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                BIT_LOW: begin
                    if (rise) begin
                        if (burst_ok) begin
                            state <= BIT_HIGH;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                BIT_HIGH: begin
                    if (fall) begin
                        if (space0_ok || space1_ok) begin
                            shreg   <= {space1_ok, shreg[31:1]};
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= (bit_cnt == 5'd31) ? STOP_LOW : BIT_LOW;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (cnt > S1_MAX) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                STOP_LOW: begin
                    if (rise) begin
                        if (burst_ok && checksum_ok) begin
                            hex_data   <= shreg;
                            data_valid <= 1'b1;
                            rpt_win    <= WIN_LOAD;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                RPT_TAIL: begin
                    if (rise) begin
                        if (burst_ok && rpt_win != '0) begin
                            repeat_valid <= 1'b1;
                            rpt_win      <= WIN_LOAD;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nec_ir_receiver.md
Name: nec_ir_receiver

Overview:
- Decodes the NEC infrared remote protocol from the demodulated IR receiver pin into a 32-bit frame.
- Sits directly upstream of the drive-mode FSM, which consumes hex_data[23:16] as the button code (0x0F, 0x13, 0x10, 0x05 and so on).
- Emits one-cycle pulses for each new valid frame and for each NEC repeat code, plus a frame-error pulse.
- hex_data holds its value between frames, so the FSM can level-compare it.

Parameters:
- LEAD_LOW_MIN, 400000: minimum leader burst, in clocks (8 ms at 50 MHz).
- LEAD_LOW_MAX, 500000: maximum leader burst (10 ms).
- GAP_DATA_MIN / GAP_DATA_MAX, 175000 / 275000: leader space range for a data frame (3.5–5.5 ms).
- GAP_RPT_MIN / GAP_RPT_MAX, 87500 / 137500: leader space range for a repeat code (1.75–2.75 ms).
- BURST_MIN / BURST_MAX, 15000 / 45000: bit burst and stop burst range (0.3–0.9 ms).
- SPACE0_MIN / SPACE0_MAX, 15000 / 45000: space range for a logic 0.
- SPACE1_MIN / SPACE1_MAX, 65000 / 105000: space range for a logic 1 (1.3–2.1 ms).
- RPT_WINDOW, 7500000: time after a valid frame (or repeat) during which a repeat code is accepted (150 ms).

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- IRDA_RXD  in  1  raw receiver output, asynchronous; low = carrier present.
- hex_data  out  32  last valid frame: [7:0] addr, [15:8] addr inverse, [23:16] command, [31:24] command inverse.
- data_valid  out  1  one-cycle pulse when hex_data is updated.
- repeat_valid  out  1  one-cycle pulse on an accepted repeat code; hex_data is unchanged.
- frame_err  out  1  one-cycle pulse on any timing or checksum failure.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs are 0 on the first rising edge with reset_n low. The state goes to IDLE, the repeat window is cleared, and the shift register and bit count are cleared. Reset mid-frame aborts the frame silently: no frame_err is emitted.
- Input conditioning: 2-flop synchronizer, then a registered copy for edge detect. An edge is seen 3 clocks after the raw transition. All durations are measured between synchronized edges.
- Duration counter: 20 bits, clears on every synchronized edge, increments otherwise, and saturates at 2^20-1.
- IDLE → LEAD_LOW on a falling edge.
- LEAD_LOW: on a rising edge, go to LEAD_HIGH if the count is in [LEAD_LOW_MIN, LEAD_LOW_MAX]; otherwise raise frame_err and return to IDLE.
- LEAD_HIGH: on a falling edge:
  - count in the data gap range: go to BIT_LOW and set bit count to 0.
  - count in the repeat gap range: go to RPT_TAIL.
  - otherwise: frame_err, IDLE.
- BIT_LOW: on a rising edge, go to BIT_HIGH if the burst is in range; otherwise frame_err, IDLE.
- BIT_HIGH: on a falling edge, a space in the SPACE0 range shifts in 0 and a space in the SPACE1 range shifts in 1. Any other value gives frame_err, IDLE.
  - Bits are shifted LSB-first into shreg[31:0]: each new bit enters bit 31 and the register shifts right, so the first bit ends at bit 0.
  - After the 32nd bit, go to STOP_LOW; otherwise go back to BIT_LOW.
- Timeout: in BIT_HIGH, a count exceeding SPACE1_MAX without an edge gives frame_err, IDLE. This timeout is checked every cycle, not only at an edge.
- STOP_LOW: on a rising edge with the burst in range, run the checksum.
  - Checksum passes (shreg[31:24] == ~shreg[23:16]): hex_data ← shreg, data_valid = 1, repeat window reloaded.
  - Checksum fails: frame_err = 1 and hex_data is kept.
  - Either way, go to IDLE.
- RPT_TAIL: on a rising edge with the burst in range, if the window is nonzero (and no valid frame has been seen since reset is impossible, as the window is 0 after reset), set repeat_valid = 1, reload the window, and go to IDLE.
  - Window expired: frame_err, IDLE.
  - Burst out of range: frame_err, IDLE.
- Repeat window: 23-bit down-counter that decrements to 0 and holds there.
- Latency: data_valid or repeat_valid is asserted exactly 4 clocks after the raw rising edge that ends the stop burst (3 clocks of sync/edge plus 1 registered output).
- Pulses: data_valid, repeat_valid and frame_err are mutually exclusive and never wider than 1 cycle.
- Idle line: a high line in IDLE does nothing, regardless of count saturation.

Optional Feature:
- Macro: IR_ADDR_CHECK_EN.
- When defined: the checksum additionally requires shreg[15:8] == ~shreg[7:0]. Extended-address remotes are then rejected with frame_err.
- When undefined: only the command byte pair is checked, and address bytes are passed through unchecked.

Test Plan:
- Reset: hold reset_n low for 2 clocks during an active leader → all outputs 0, busy 0. After release, no frame_err.
- Valid frame, addr 0x00, cmd 0x0F: 9 ms / 4.5 ms leader, 32 bits, 560 µs stop → hex_data = 0xF00FFF00. data_valid is high for exactly 1 cycle, 4 clocks after the stop rising edge.
- Repeat: after the frame above, send a repeat (9 ms / 2.25 ms / 560 µs) 40 ms later → repeat_valid is one pulse and hex_data stays 0xF00FFF00. The same repeat sent 200 ms after the last accepted event → frame_err, no repeat_valid.
- Checksum failure with cmd 0x13, inverse byte 0xED → frame_err pulse, hex_data unchanged.
- Address check: addr 0x04, inverse 0x00, cmd 0x10 valid → data_valid, hex_data = 0xEF10_0004 when IR_ADDR_CHECK_EN is undefined; frame_err when it is defined.
- Timing errors:
  - 3 ms space after bit 12 → frame_err at SPACE1_MAX+1 cycles into the space, then IDLE.
  - 5 ms leader → frame_err on its rising edge.
  - A valid frame immediately afterwards decodes correctly.
